// File: rtl/ram_sweep_ctrl_if.sv
// RAM-side port bundle for ram_sweep_ctrl: read/write addresses, write data and registered read data.
interface ram_sweep_ctrl_if #(
    parameter int unsigned WID_MEM = 18,
    parameter int unsigned ADDR_W  = 12
);
    logic [ADDR_W-1:0]  raddr;
    logic [ADDR_W-1:0]  waddr;
    logic [WID_MEM-1:0] din;
    logic [WID_MEM-1:0] dout;

    modport master (output raddr, output waddr, output din, input dout);
    modport slave  (input raddr, input waddr, input din, output dout);
endinterface

// File: rtl/ram_sweep_ctrl.sv
// Sweep sequencer for a simple-dual-port RAM: preserving write-back when quiet,
// rotate-XOR checksum sweep on command, optional deterministic fill afterwards.
module ram_sweep_ctrl #(
    parameter int unsigned WID_MEM   = 18,
    parameter int unsigned DEPTH_MEM = 4096,
    parameter int unsigned ADDR_W    = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               fill,
    input  logic [WID_MEM-1:0] seed,
    ram_sweep_ctrl_if.master   ram,
    output logic               busy,
    output logic               done,
    output logic [WID_MEM-1:0] checksum,
    output logic               chk_valid
);

    typedef enum logic [2:0] {StIdle, StCheck, StCheckDrain, StFill, StSettle} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH_MEM - 1);

    state_e             state_q;
    logic [ADDR_W-1:0]  raddr_q;
    logic [ADDR_W-1:0]  raddr_d;  // raddr delayed one edge; write-back target
    logic               fill_q;
    logic [WID_MEM-1:0] seed_q;

    function automatic logic [WID_MEM-1:0] rotl1(input logic [WID_MEM-1:0] v);
        return {v[WID_MEM-2:0], v[WID_MEM-1]};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            raddr_q   <= '0;
            raddr_d   <= '0;
            fill_q    <= 1'b0;
            seed_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= '0;
            chk_valid <= 1'b0;
        end else begin
            done    <= 1'b0;
            raddr_d <= raddr_q;
            unique case (state_q)
                StIdle: begin
                    raddr_q <= '0;
                    if (start) begin
                        fill_q    <= fill;
                        seed_q    <= seed;
                        checksum  <= '0;
                        chk_valid <= 1'b0;
                        busy      <= 1'b1;
                        state_q   <= StCheck;
                    end
                end
                StCheck: begin
                    // dout carries ram[raddr_q-1] here; nothing valid yet while raddr_q is 0
                    if (raddr_q != '0) begin
                        checksum <= rotl1(checksum) ^ ram.dout;
                    end
                    if (raddr_q == LastAddr) begin
                        raddr_q <= '0;
                        state_q <= StCheckDrain;
                    end else begin
                        raddr_q <= raddr_q + 1'b1;
                    end
                end
                StCheckDrain: begin
                    checksum  <= rotl1(checksum) ^ ram.dout;
                    chk_valid <= 1'b1;
                    raddr_q   <= '0;
                    if (fill_q) begin
                        state_q <= StFill;
                    end else begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StFill: begin
                    // raddr_q doubles as the fill counter
                    if (raddr_q == LastAddr) begin
                        raddr_q <= '0;
                        state_q <= StSettle;
                    end else begin
                        raddr_q <= raddr_q + 1'b1;
                    end
                end
                StSettle: begin
                    raddr_d <= '0;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ram.raddr = raddr_q;

    always_comb begin
        ram.waddr = raddr_d;
        ram.din   = ram.dout;
        unique case (state_q)
            StFill: begin
                ram.waddr = raddr_q;
                ram.din   = seed_q + WID_MEM'(raddr_q);
            end
            StSettle: begin
                ram.waddr = LastAddr;
                ram.din   = seed_q + WID_MEM'(LastAddr);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_sweep_ctrl.sv
// Bench for ram_sweep_ctrl: behavioural RAM plus array-level reference model of checksum and fill.
module tb_ram_sweep_ctrl;

    localparam int unsigned W = 18;
    localparam int unsigned D = 4096;
    localparam int unsigned A = 12;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         fill = 1'b0;
    logic [W-1:0] seed = '0;
    logic         busy, done, chk_valid;
    logic [W-1:0] checksum;

    ram_sweep_ctrl_if #(.WID_MEM(W), .ADDR_W(A)) bus ();

    ram_sweep_ctrl #(.WID_MEM(W), .DEPTH_MEM(D), .ADDR_W(A)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .fill      (fill),
        .seed      (seed),
        .ram       (bus),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum),
        .chk_valid (chk_valid)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem      [D];
    logic [W-1:0] init_img [D];
    logic [W-1:0] ref_mem  [D];
    bit           load_req = 1'b0;

    // Read-first registered RAM; load_req copies a whole image in one edge
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < D; i++) mem[i] <= init_img[i];
            bus.dout <= init_img[bus.raddr];
        end else begin
            bus.dout <= mem[bus.raddr];
            mem[bus.waddr] <= bus.din;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_sum();
        logic [W-1:0] s = '0;
        for (int i = 0; i < D; i++) s = ((s << 1) | (s >> (W - 1))) ^ ref_mem[i];
        return s;
    endfunction

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < D; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    task automatic load_image();
        for (int i = 0; i < D; i++) ref_mem[i] = init_img[i];
        @(negedge clk) load_req = 1'b1;
        @(negedge clk) load_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_cmd(input logic f, input logic [W-1:0] s, input bit poke,
                           input bit chk_sum, input string tag);
        logic [W-1:0] exp_sum;
        int exp_done, n, ndone, first;
        exp_sum  = model_sum();
        exp_done = f ? 2 * D + 2 : D + 1;
        @(negedge clk);
        start = 1'b1;
        fill  = f;
        seed  = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        fill  = ~f;
        seed  = ~s;
        check({tag, " busy after start"}, 32'(busy), 32'd1);
        check({tag, " chk_valid cleared"}, 32'(chk_valid), 32'd0);
        n = 0;
        ndone = 0;
        first = -1;
        while (n < exp_done + 8) begin
            @(posedge clk);
            n++;
            #1;
            if (poke && n == 50) begin
                check({tag, " raddr mid-check"}, 32'(bus.raddr), 32'd50);
                check({tag, " waddr mid-check"}, 32'(bus.waddr), 32'd49);
            end
            if (poke && n == 99) start = 1'b1;
            if (poke && n == 100) start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = n;
                    check({tag, " busy at done"}, 32'(busy), 32'd0);
                    check({tag, " chk_valid at done"}, 32'(chk_valid), 32'd1);
                    if (chk_sum) check({tag, " checksum"}, 32'(checksum), 32'(exp_sum));
                end
            end
        end
        check({tag, " done edge"}, 32'(first), 32'(exp_done));
        check({tag, " done pulses"}, 32'(ndone), 32'd1);
        check({tag, " idle after"}, 32'(busy), 32'd0);
        if (f) for (int i = 0; i < D; i++) ref_mem[i] = s + W'(i);
    endtask

    initial begin
        logic [W-1:0] s;
        int viol;

        repeat (3) @(posedge clk);
        #1;
        check("rst raddr", 32'(bus.raddr), 32'd0);
        check("rst waddr", 32'(bus.waddr), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst checksum", 32'(checksum), 32'd0);
        check("rst chk_valid", 32'(chk_valid), 32'd0);
        @(negedge clk) reset = 1'b1;

        // Single set bit at address 0 ends up rotated left by 4095 mod 18 = 9
        for (int i = 0; i < D; i++) init_img[i] = '0;
        init_img[0] = 18'h00001;
        load_image();
        run_cmd(1'b0, W'($urandom), 1'b0, 1'b1, "onehot");
        check("onehot checksum const", 32'(checksum), 32'h200);
        check("onehot mem preserved", 32'(mem_diffs()), 32'd0);

        for (int i = 0; i < D; i++) init_img[i] = '0;
        load_image();
        run_cmd(1'b0, '0, 1'b0, 1'b1, "zero1");
        check("zero1 checksum const", 32'(checksum), 32'd0);
        run_cmd(1'b0, '0, 1'b0, 1'b1, "zero2");
        check("zero2 mem preserved", 32'(mem_diffs()), 32'd0);

        run_cmd(1'b1, '0, 1'b0, 1'b1, "fill0");
        check("fill0 ram[5]", 32'(mem[5]), 32'h5);
        check("fill0 ram[4095]", 32'(mem[4095]), 32'hFFF);
        check("fill0 mem", 32'(mem_diffs()), 32'd0);
        run_cmd(1'b0, '0, 1'b0, 1'b1, "fill0 recheck");

        run_cmd(1'b1, 18'h3FFF0, 1'b0, 1'b1, "wrap");
        check("wrap ram[f]", 32'(mem[15]), 32'h3FFFF);
        check("wrap ram[10]", 32'(mem[16]), 32'h0);
        check("wrap mem", 32'(mem_diffs()), 32'd0);

        for (int i = 0; i < D; i++) init_img[i] = W'($urandom);
        load_image();
        run_cmd(1'b0, W'($urandom), 1'b1, 1'b1, "rand poke");
        viol = 0;
        repeat (1000) begin
            @(posedge clk);
            #1;
            if (bus.waddr !== '0 || bus.raddr !== '0 || busy !== 1'b0) viol++;
        end
        check("idle hold addr", 32'(viol), 32'd0);
        check("idle mem preserved", 32'(mem_diffs()), 32'd0);

        // Reset during FILL, just after fill write 2000 has landed
        s = W'($urandom);
        @(negedge clk);
        start = 1'b1;
        fill  = 1'b1;
        seed  = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        fill  = 1'b0;
        repeat (D + 2 + 2000) @(posedge clk);
        #1;
        check("fill raddr", 32'(bus.raddr), 32'd2001);
        check("fill waddr", 32'(bus.waddr), 32'd2001);
        check("fill din", 32'(bus.din), 32'(s + W'(2001)));
        reset = 1'b0;
        #1;
        check("mid rst raddr", 32'(bus.raddr), 32'd0);
        check("mid rst waddr", 32'(bus.waddr), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst done", 32'(done), 32'd0);
        check("mid rst checksum", 32'(checksum), 32'd0);
        check("mid rst chk_valid", 32'(chk_valid), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (4) @(negedge clk);
        viol = 0;
        for (int i = 1; i <= 1998; i++) if (mem[i] !== s + W'(i)) viol++;
        check("rst filled region", 32'(viol), 32'd0);
        viol = 0;
        for (int i = 2004; i < D; i++) if (mem[i] !== ref_mem[i]) viol++;
        check("rst untouched region", 32'(viol), 32'd0);

        run_cmd(1'b1, W'($urandom), 1'b0, 1'b0, "refill");
        check("refill mem", 32'(mem_diffs()), 32'd0);
        run_cmd(1'b0, W'($urandom), 1'b0, 1'b1, "final check");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
